pc_reg: RTL and testbench

PC_REG -- requirements
Module: pc_reg

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_incr.sv | 21 ++
 rtl/pc_reg.sv | 78 +++++++
 tb/tb_pc_reg.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared constants and types for the program-counter register slice.
//   PC_WIDTH        default program-counter width (64)
//   PC_RESET_VECTOR default value the PC takes while in reset (0)
//   PC_STEP         default sequential-fetch increment (4)
//   pc_t            64-bit program-counter type
//   pc_misaligned() true when the low two address bits are non-zero
// -----------------------------------------------------------------------------
package pc_pkg;

    localparam int          PC_WIDTH        = 64;
    localparam logic [63:0] PC_RESET_VECTOR = 64'h0;
    localparam int          PC_STEP         = 4;

    typedef logic [63:0] pc_t;

    // A fetch address is word-aligned only when bits [1:0] are both zero.
    function automatic logic pc_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/pc_incr.sv
// -----------------------------------------------------------------------------
// pc_incr
// Sequential-fetch adder: pc_next = (pc + STEP) mod 2^WIDTH. The carry out of
// the top bit is dropped, so the all-ones region wraps back to zero.
// Ports:
//   pc       in  [WIDTH-1:0]  current program counter
//   pc_next  out [WIDTH-1:0]  pc + STEP, combinational
// -----------------------------------------------------------------------------
module pc_incr
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int STEP  = PC_STEP
) (
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next
);

    assign pc_next = pc + WIDTH'(STEP);

endmodule

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program-counter register. Loads IN on every rising clk edge (no enable, no
// stall) and presents the registered value on OUT. OUT_NEXT is the
// combinational sequential-fetch address OUT + STEP.
//
// Optional feature (macro PC_ALIGN_CHECK_EN): adds a registered ALIGN_ERR flag
// captured alongside OUT, set when IN[1:0] != 2'b00. Without the macro the
// port and its logic do not exist.
//
// Ports:
//   clk        in                 rising-edge clock
//   rst        in                 asynchronous, active-low reset
//   IN         in  [WIDTH-1:0]    next program-counter value, taken verbatim
//   OUT        out [WIDTH-1:0]    current program counter (registered)
//   OUT_NEXT   out [WIDTH-1:0]    OUT + STEP (combinational, wraps)
//   ALIGN_ERR  out                registered misalignment flag
//                                 (PC_ALIGN_CHECK_EN only)
// -----------------------------------------------------------------------------
module pc_reg
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter int               STEP         = PC_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] IN,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_NEXT
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             ALIGN_ERR
`endif
);

    logic [WIDTH-1:0] pc_p0;

    // Stage p0: PC capture. Reset is asynchronous so OUT snaps to the reset
    // vector without a clock; a release coincident with an edge must meet
    // recovery timing so that edge still sees reset and the first load is
    // the following edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_p0 <= RESET_VECTOR;
        end else begin
            pc_p0 <= IN;
        end
    end

    assign OUT = pc_p0;

`ifdef PC_ALIGN_CHECK_EN
    logic align_err_p0;

    // Stage p0: misalignment flag, registered in step with the PC so it
    // always describes the value currently on OUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            align_err_p0 <= 1'b0;
        end else begin
            align_err_p0 <= pc_misaligned(IN[1:0]);
        end
    end

    assign ALIGN_ERR = align_err_p0;
`endif

    pc_incr #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_incr (
        .pc      (pc_p0),
        .pc_next (OUT_NEXT)
    );

endmodule

// File: tb/tb_pc_reg.sv
// -----------------------------------------------------------------------------
// tb_pc_reg
// Directed bench for pc_reg with default parameters (WIDTH=64, RESET_VECTOR=0,
// STEP=4). Expected PC values are queued when IN is driven and popped after
// the capturing edge. ALIGN_ERR is checked when PC_ALIGN_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_pc_reg;
    import pc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    pc_t  in_v = '0;
    pc_t  out_v;
    pc_t  out_next_v;
`ifdef PC_ALIGN_CHECK_EN
    logic align_err_v;
`endif

    int checks = 0;
    int errors = 0;

    pc_t  exp_pc_q[$];
    logic exp_al_q[$];

    pc_reg dut (
        .clk       (clk),
        .rst       (rst),
        .IN        (in_v),
        .OUT       (out_v),
        .OUT_NEXT  (out_next_v)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .ALIGN_ERR (align_err_v)
`endif
    );

    // Rising edges at 5, 15, 25 ... ns
    always #5 clk = ~clk;

    task automatic check(input string tag, input pc_t observed, input pc_t expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive IN and record what the next edge must produce.
    task automatic drive(input pc_t value);
        in_v = value;
        exp_pc_q.push_back(value);
        exp_al_q.push_back(value[1:0] != 2'b00);
    endtask

    // Wait for the capturing edge, then compare against the scoreboard.
    task automatic edge_and_check(input string tag);
        pc_t  exp_pc;
        logic exp_al;
        @(posedge clk);
        #1;
        if (exp_pc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, observed %h expected an entry", tag, out_v);
        end else begin
            exp_pc = exp_pc_q.pop_front();
            exp_al = exp_al_q.pop_front();
            check({tag, ".out"}, out_v, exp_pc);
            check({tag, ".out_next"}, out_next_v, exp_pc + 64'd4);
`ifdef PC_ALIGN_CHECK_EN
            check({tag, ".align"}, {63'b0, align_err_v}, {63'b0, exp_al});
`endif
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".out"}, out_v, 64'h0);
        check({tag, ".out_next"}, out_next_v, 64'h4);
`ifdef PC_ALIGN_CHECK_EN
        check({tag, ".align"}, {63'b0, align_err_v}, 64'h0);
`endif
    endtask

    initial begin
        // Reset asserted from time 0: state visible before any edge.
        #1;
        check_reset_state("reset_t0");

        // Release reset on the 5 ns edge; IN is zero so that edge cannot
        // change OUT whichever way it is ordered.
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("post_release.out", out_v, 64'h0);

        // IN applied at 8 ns, captured at 15 ns.
        #2;
        drive(64'hFFFFFFFF_AAAAAAAA);
        edge_and_check("first_load");

        // Successive loads, one edge latency each.
        drive(64'hAAAAAAAA_FFFFFFFF);
        edge_and_check("seq_a");
        drive(64'h0);
        edge_and_check("seq_zero");
        drive(64'hAAAAAAAA_BBBBBBBB);
        edge_and_check("seq_b");

        // IN changes twice between edges; OUT holds until the edge and then
        // takes only the value present at it.
        in_v = 64'h1234_5678_9ABC_DEF1;
        #2;
        check("hold1.out", out_v, 64'hAAAAAAAA_BBBBBBBB);
        in_v = 64'h0F0F_0F0F_0F0F_0F0E;
        #2;
        check("hold2.out", out_v, 64'hAAAAAAAA_BBBBBBBB);
        drive(64'h0000_0000_0000_1000);
        edge_and_check("double_change");

        // Wrap-around of OUT_NEXT and all-ones input.
        drive(64'hFFFFFFFF_FFFFFFFC);
        edge_and_check("wrap");
        check("wrap.out_next_zero", out_next_v, 64'h0);
        drive(64'hFFFFFFFF_FFFFFFFF);
        edge_and_check("all_ones");

        // Mid-cycle asynchronous reset while OUT holds a loaded value.
        drive(64'hAAAAAAAA_BBBBBBBB);
        edge_and_check("pre_reset");
        in_v = 64'h5555_5555_5555_5555;
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("async_reset");

        // Edge while held in reset must not load IN.
        @(posedge clk);
        #1;
        check_reset_state("held_reset");

        // Release mid-cycle; the next edge loads normally.
        #2;
        rst = 1'b1;
        drive(64'h0000_0000_8000_0002);
        edge_and_check("after_release");
        drive(64'h0000_0000_0000_0008);
        edge_and_check("after_release2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
